fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the instruction cache. It owns the program counter and issues one word-aligned fetch request at a time on the cache's CPU-side request/response handshake. Returned instructions, tagged with their PC, are buffered in a small FIFO that feeds decode. Redirects from branch/jump/exception/FENCE.I resolution flush the FIFO and discard any in-flight response.

---
 rtl/fetch_unit_if.sv | 23 ++
 rtl/fetch_unit.sv | 103 ++++++++++
 tb/tb_fetch_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// CPU-side request/response handshake between the fetch stage and the I$.
// master = fetch unit, slave = instruction cache.
interface fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 32
);
  logic                   cpu_req_valid_o;
  logic [ADDR_WIDTH-1:0]  cpu_addr_o;
  logic                   icache_req_ready_i;
  logic                   icache_resp_valid_i;
  logic [INSTR_WIDTH-1:0] icache_resp_instr_i;
  logic                   cpu_resp_ready_o;

  modport master (
    output cpu_req_valid_o, cpu_addr_o, cpu_resp_ready_o,
    input  icache_req_ready_i, icache_resp_valid_i, icache_resp_instr_i
  );

  modport slave (
    input  cpu_req_valid_o, cpu_addr_o, cpu_resp_ready_o,
    output icache_req_ready_i, icache_resp_valid_i, icache_resp_instr_i
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one I$ request in flight and
// buffers returned {pc, instr} pairs in a small FIFO feeding decode.
module fetch_unit #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned           FQ_DEPTH    = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
  fetch_unit_if.master           ic,
  output logic                   instr_valid_o,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]  instr_pc_o,
  input  logic                   decode_ready_i
);
  localparam int unsigned     PTR_W = $clog2(FQ_DEPTH);
  localparam logic [PTR_W:0]  FULL  = (PTR_W+1)'(FQ_DEPTH);

  typedef enum logic [1:0] {F_REQ, F_WAIT, F_DROP} state_t;

  state_t                 r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]  r_fetch_pc;
  logic [ADDR_WIDTH-1:0]  r_fq_pc    [FQ_DEPTH];
  logic [INSTR_WIDTH-1:0] r_fq_instr [FQ_DEPTH];
  logic [PTR_W-1:0]       r_rd_ptr, r_wr_ptr;
  logic [PTR_W:0]         r_count;

  logic w_req_valid, w_resp_fire, w_push, w_pop;

  assign w_req_valid = (r_state == F_REQ) && (r_count != FULL) && !redirect_valid_i;
  assign w_resp_fire = (r_state != F_REQ) && ic.icache_resp_valid_i;
  assign w_push      = (r_state == F_WAIT) && w_resp_fire && !redirect_valid_i;
  assign w_pop       = (r_count != '0) && decode_ready_i;

  assign ic.cpu_req_valid_o  = w_req_valid;
  assign ic.cpu_addr_o       = r_fetch_pc;
  assign ic.cpu_resp_ready_o = (r_state != F_REQ);

  assign instr_valid_o = (r_count != '0);
  assign instr_o       = r_fq_instr[r_rd_ptr];
  assign instr_pc_o    = r_fq_pc[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= F_REQ;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      F_REQ: begin
        if (w_req_valid && ic.icache_req_ready_i) w_state_nxt = F_WAIT;
      end
      // A response landing with a redirect is dropped, so no F_DROP is needed
      F_WAIT: begin
        if (w_resp_fire)           w_state_nxt = F_REQ;
        else if (redirect_valid_i) w_state_nxt = F_DROP;
      end
      F_DROP: begin
        if (w_resp_fire) w_state_nxt = F_REQ;
      end
      default: w_state_nxt = F_REQ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fetch_pc <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      for (int unsigned i = 0; i < FQ_DEPTH; i++) begin
        r_fq_pc[i]    <= '0;
        r_fq_instr[i] <= '0;
      end
    end else if (redirect_valid_i) begin
      // Redirect overrides any same-cycle push or pop
      r_fetch_pc <= {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_fq_pc[r_wr_ptr]    <= r_fetch_pc;
        r_fq_instr[r_wr_ptr] <= ic.icache_resp_instr_i;
        r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
        r_fetch_pc           <= r_fetch_pc + ADDR_WIDTH'(4);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  a_no_resp_in_req: assert property (@(posedge clk_i) disable iff (rst_i)
    !((r_state == F_REQ) && ic.icache_resp_valid_i));
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order fetch, full queue, redirects,
// PC wrap and reset with a request outstanding.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        decode_ready;

  int total = 0;
  int bad   = 0;

  fetch_unit_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) ic ();

  fetch_unit #(
    .ADDR_WIDTH (32),
    .INSTR_WIDTH(32),
    .RESET_PC   (32'h0000_0000),
    .FQ_DEPTH   (4)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .redirect_valid_i(redirect_valid),
    .redirect_pc_i   (redirect_pc),
    .ic              (ic),
    .instr_valid_o   (instr_valid),
    .instr_o         (instr),
    .instr_pc_o      (instr_pc),
    .decode_ready_i  (decode_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // From F_REQ: issue at exp_addr, answer next cycle with ins, then check the head.
  task automatic fetch_one(input logic [31:0] exp_addr, input logic [31:0] ins,
                           input logic [31:0] head_pc, input logic [31:0] head_instr);
    chk("req_valid", {31'b0, ic.cpu_req_valid_o}, 32'd1);
    chk("req_addr", ic.cpu_addr_o, exp_addr);
    tick();
    ic.icache_resp_valid_i = 1'b1;
    ic.icache_resp_instr_i = ins;
    #1;
    chk("wait_resp_ready", {31'b0, ic.cpu_resp_ready_o}, 32'd1);
    chk("wait_no_req", {31'b0, ic.cpu_req_valid_o}, 32'd0);
    tick();
    ic.icache_resp_valid_i = 1'b0;
    ic.icache_resp_instr_i = '0;
    #1;
    chk("head_valid", {31'b0, instr_valid}, 32'd1);
    chk("head_pc", instr_pc, head_pc);
    chk("head_instr", instr, head_instr);
  endtask

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    decode_ready = 1'b1;
    ic.icache_req_ready_i = 1'b1;
    ic.icache_resp_valid_i = 1'b0;
    ic.icache_resp_instr_i = '0;

    // Reset state
    tick();
    rst = 1'b0;
    #1;
    chk("rst_req_valid", {31'b0, ic.cpu_req_valid_o}, 32'd1);
    chk("rst_addr", ic.cpu_addr_o, 32'h0);
    chk("rst_resp_ready", {31'b0, ic.cpu_resp_ready_o}, 32'd0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);

    // In-order fetch with decode always ready: 0x0, 0x4, 0x8, 0xC
    for (int k = 0; k < 4; k++)
      fetch_one(32'(4 * k), 32'hA000_0000 + 32'(k), 32'(4 * k), 32'hA000_0000 + 32'(k));

    // Hold decode: 0xC stays at head while 0x10..0x18 fill the queue
    decode_ready = 1'b0;
    for (int k = 4; k < 7; k++)
      fetch_one(32'(4 * k), 32'hA000_0000 + 32'(k), 32'hC, 32'hA000_0003);
    chk("full_no_req", {31'b0, ic.cpu_req_valid_o}, 32'd0);
    chk("full_addr_held", ic.cpu_addr_o, 32'h1C);
    tick();
    chk("full_still_no_req", {31'b0, ic.cpu_req_valid_o}, 32'd0);
    decode_ready = 1'b1;
    #1;
    chk("full_pop_no_req", {31'b0, ic.cpu_req_valid_o}, 32'd0);
    tick();
    decode_ready = 1'b0;
    #1;
    chk("after_pop_req", {31'b0, ic.cpu_req_valid_o}, 32'd1);
    chk("after_pop_addr", ic.cpu_addr_o, 32'h1C);
    chk("after_pop_head", instr_pc, 32'h10);

    // Redirect while F_WAIT, stale response three cycles later
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_1003;
    #1;
    chk("redir_wait_resp_ready", {31'b0, ic.cpu_resp_ready_o}, 32'd1);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("drop_flushed", {31'b0, instr_valid}, 32'd0);
    chk("drop_no_req", {31'b0, ic.cpu_req_valid_o}, 32'd0);
    chk("drop_resp_ready", {31'b0, ic.cpu_resp_ready_o}, 32'd1);
    tick();
    tick();
    chk("drop_still_no_req", {31'b0, ic.cpu_req_valid_o}, 32'd0);
    ic.icache_resp_valid_i = 1'b1;
    ic.icache_resp_instr_i = 32'hDEAD_BEEF;
    tick();
    ic.icache_resp_valid_i = 1'b0;
    decode_ready = 1'b1;
    #1;
    chk("drop_discarded", {31'b0, instr_valid}, 32'd0);
    fetch_one(32'h1000, 32'hC0DE_0001, 32'h1000, 32'hC0DE_0001);

    // Redirect in the same cycle the response is accepted
    tick();
    ic.icache_resp_valid_i = 1'b1;
    ic.icache_resp_instr_i = 32'hBAD0_0BAD;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_2000;
    tick();
    ic.icache_resp_valid_i = 1'b0;
    redirect_valid = 1'b0;
    #1;
    chk("samecyc_no_push", {31'b0, instr_valid}, 32'd0);
    chk("samecyc_req", {31'b0, ic.cpu_req_valid_o}, 32'd1);
    chk("samecyc_addr", ic.cpu_addr_o, 32'h2000);

    // Redirect in F_REQ to an unaligned top address, then wrap
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    #1;
    chk("redir_masks_req", {31'b0, ic.cpu_req_valid_o}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    fetch_one(32'hFFFF_FFFC, 32'h1234_5678, 32'hFFFF_FFFC, 32'h1234_5678);
    chk("wrap_addr", ic.cpu_addr_o, 32'h0);
    decode_ready = 1'b0;

    // Reset while F_WAIT with two queued entries
    fetch_one(32'h0, 32'h8765_4321, 32'hFFFF_FFFC, 32'h1234_5678);
    tick();
    chk("pre_rst_wait", {31'b0, ic.cpu_resp_ready_o}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("midrst_addr", ic.cpu_addr_o, 32'h0);
    chk("midrst_req", {31'b0, ic.cpu_req_valid_o}, 32'd1);
    chk("midrst_resp_ready", {31'b0, ic.cpu_resp_ready_o}, 32'd0);
    chk("midrst_instr_pc", instr_pc, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
